corelet_ctrl: RTL and testbench
===============================

# corelet_ctrl

Layer sequencer for the corelet: drives the 35-bit corelet instruction word and the activation/weight SRAM read port so that one full convolution layer (n_kij kernel positions × n_nij activation vectors) runs without host intervention. Sits between the host/testbench `start` pulse and the corelet, consuming L0/OFIFO status flags and producing L0 write/read, MAC kernel-load/execute, OFIFO read and SFP accumulate strobes in the correct order.

## Interface
- row, 8, PE rows / L0 lanes
- col, 8, PE columns / weight vectors per kernel position
- addr_bw, 11, xmem address width
- cnt_bw, 8, width of loop counters and length inputs

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE
- mode  in  1  0 = weight-stationary, 1 = output-stationary (see Configuration)
- n_kij  in  cnt_bw  kernel positions, ≥1, sampled on accepted start
- n_nij  in  cnt_bw  activation vectors per position, ≥1, sampled on start
- w_base, a_base  in  addr_bw each  xmem base addresses, sampled on start
- l0_full  in  1  L0 almost-full (≥1 free entry remains when high)
- l0_ready  in  1  L0 has data for every lane
- ofifo_valid  in  1  OFIFO has a complete output row
- inst  out  35  corelet instruction: [34] mode, [33] sfp_acc, [6] ofifo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] kernel_load; all other bits 0
- xmem_cen  out  1  SRAM chip enable, active-low
- xmem_addr  out  addr_bw  SRAM read address
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on layer completion

## Operation
- States: IDLE, W_WR, W_LOAD, W_FLUSH, A_WR, EXEC, DRAIN, NEXT, DONE.
- IDLE → W_WR on start; kij=0.
- W_WR: issue col reads at w_base + kij·col + i; issue only when l0_full=0; l0_wr is the issue strobe delayed one cycle (SRAM latency 1). Exit after last write lands.
- W_LOAD: kernel_load=1 and l0_rd=1 for col cycles where l0_ready=1; stalled cycles hold both low.
- W_FLUSH: row+col idle cycles (counter), then A_WR.
- A_WR: n_nij reads at a_base + j, same gating/latency as W_WR.
- EXEC: execute=1, l0_rd=1 on each l0_ready cycle, n_nij counted reads.
- DRAIN: ofifo_rd=1 and sfp_acc=1 in the same cycle whenever ofifo_valid=1; exit after n_nij reads.
- NEXT: kij+1; kij==n_kij → DONE else W_WR.
- DONE: done=1 one cycle → IDLE.
- start outside IDLE ignored. inst[34]=mode sampled on start, held until IDLE.
- Counters saturate-free: compare against sampled length minus 1; addresses wrap modulo 2^addr_bw.

## Timing
- Reset: inst=0, xmem_cen=1, xmem_addr=0, busy=0, done=0, state IDLE, all counters 0; applies immediately mid-layer, in-flight SRAM read discarded (no l0_wr after reset).
- All outputs registered.
- start at cycle t → busy=1 and first xmem_cen=0 at t+1; first l0_wr at t+2.
- Read issue stops the cycle l0_full is seen high; exactly one in-flight write may land afterward.
- Unstalled W_WR lasts col+1 cycles; W_LOAD col; W_FLUSH row+col; A_WR n_nij+1; EXEC n_nij.
- done pulses the cycle after final DRAIN read; busy drops with done's following cycle.

## Configuration
- CORELET_CTRL_OS_EN defined: mode=1 accepted; sequence per kij is A_WR → EXEC → W_FLUSH (no W_WR/W_LOAD/DRAIN, ofifo_rd/sfp_acc never asserted); inst[34]=1.
- Undefined: mode ignored, inst[34] tied 0, always weight-stationary sequence.

## Test plan
- WS, n_kij=1, n_nij=4, no stalls, w_base=0, a_base=16 -> addresses 0..7 then 16..19; 8 kernel_load, 4 execute, 4 ofifo_rd+sfp_acc pulses; one done.
- n_kij=3, n_nij=2 -> weight addresses 0..23 in order, 6 sfp_acc pulses total, done once at end.
- l0_full held high 5 cycles mid A_WR -> no xmem reads while high, at most one l0_wr after rise, total l0_wr count unchanged.
- ofifo_valid toggling 1/0 in DRAIN -> ofifo_rd only on valid cycles, exit after exactly n_nij reads.
- reset asserted in EXEC -> next cycle inst=0, xmem_cen=1, busy=0; new start runs full layer correctly.
- CORELET_CTRL_OS_EN, mode=1, n_kij=2 -> zero kernel_load/ofifo_rd, inst[34]=1 while busy, done pulse.

Source files
------------

// File: rtl/corelet_ctrl_if.sv
// corelet_ctrl_if: host/corelet-facing signal bundle of the layer sequencer.
// master = the sequencer itself, slave = host, L0/OFIFO and SRAM side.
interface corelet_ctrl_if #(
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 8
);
    logic               start;
    logic               mode;
    logic [cnt_bw-1:0]  n_kij;
    logic [cnt_bw-1:0]  n_nij;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] a_base;
    logic               l0_full;
    logic               l0_ready;
    logic               ofifo_valid;
    logic [34:0]        inst;
    logic               xmem_cen;
    logic [addr_bw-1:0] xmem_addr;
    logic               busy;
    logic               done;

    modport master (
        input  start, mode, n_kij, n_nij, w_base, a_base, l0_full, l0_ready, ofifo_valid,
        output inst, xmem_cen, xmem_addr, busy, done
    );

    modport slave (
        output start, mode, n_kij, n_nij, w_base, a_base, l0_full, l0_ready, ofifo_valid,
        input  inst, xmem_cen, xmem_addr, busy, done
    );
endinterface

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: layer sequencer. Walks n_kij kernel positions, each doing
// weight fill -> kernel load -> flush -> activation fill -> execute -> drain.
// Optional output-stationary mode is built in when CORELET_CTRL_OS_EN is
// defined (per kij: A_WR -> EXEC -> W_FLUSH).
//
// Every strobe is registered: the decision for cycle c+1 is made in cycle c
// from the status flags seen in cycle c. Each phase counts its decisions in
// icnt; a phase ends when its final strobe is visible on the outputs.
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 8
) (
    input logic clk,
    input logic reset,
    corelet_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, W_WR, W_LOAD, W_FLUSH, A_WR, EXEC, DRAIN, NEXT, DONE
    } state_t;

    state_t             st, ns;
    logic [cnt_bw-1:0]  kij, n_kij_r, n_nij_r;
    logic [cnt_bw-1:0]  icnt, icnt_base, icnt_n, len, n_sel, kij_sel;
    logic [addr_bw-1:0] w_base_r, a_base_r, w_sel, a_sel, addr_n, addr_q;
    logic               os_sel, issue, avail, last_kij;
    logic               cen_q, l0_wr_q, l0_rd_q, exec_q, kload_q, ofifo_q, mode_q;
    logic               busy_q, done_q;

`ifdef CORELET_CTRL_OS_EN
    logic os_r;
    // Mode is taken live on the start cycle, from the sampled copy afterwards.
    assign os_sel = (st == IDLE) ? bus.mode : os_r;

    // Capture the dataflow mode with the rest of the layer parameters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         os_r <= 1'b0;
        else if (st == IDLE && bus.start)  os_r <= bus.mode;
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode;
    assign os_sel      = 1'b0;
`endif

    // Start-cycle decisions use the live inputs; registers are not loaded yet.
    assign n_sel    = (st == IDLE) ? bus.n_nij  : n_nij_r;
    assign w_sel    = (st == IDLE) ? bus.w_base : w_base_r;
    assign a_sel    = (st == IDLE) ? bus.a_base : a_base_r;
    assign kij_sel  = (st == IDLE) ? '0 : kij;
    assign last_kij = (kij == n_kij_r - cnt_bw'(1));

    // Next state, then the strobe decision for the state being entered.
    always_comb begin
        ns        = st;
        issue     = 1'b0;
        len       = '0;
        case (st)
            IDLE:    if (bus.start) ns = os_sel ? A_WR : W_WR;
            W_WR:    if (l0_wr_q && cen_q && icnt == cnt_bw'(col)) ns = W_LOAD;
            W_LOAD:  if (kload_q && icnt == cnt_bw'(col)) ns = W_FLUSH;
            W_FLUSH: if (icnt == cnt_bw'(row + col))
                         ns = os_sel ? (last_kij ? DONE : NEXT) : A_WR;
            A_WR:    if (l0_wr_q && cen_q && icnt == n_nij_r) ns = EXEC;
            EXEC:    if (exec_q && icnt == n_nij_r) ns = os_sel ? W_FLUSH : DRAIN;
            DRAIN:   if (ofifo_q && icnt == n_nij_r) ns = last_kij ? DONE : NEXT;
            NEXT:    ns = os_sel ? A_WR : W_WR;
            DONE:    ns = IDLE;
            default: ns = IDLE;
        endcase

        icnt_base = (ns != st) ? '0 : icnt;
        case (ns)
            W_WR, W_LOAD:      len = cnt_bw'(col);
            A_WR, EXEC, DRAIN: len = n_sel;
            default:           len = '0;
        endcase
        avail = (icnt_base != len);

        case (ns)
            W_WR, A_WR:   issue = avail && !bus.l0_full;
            W_LOAD, EXEC: issue = avail && bus.l0_ready;
            DRAIN:        issue = avail && bus.ofifo_valid;
            W_FLUSH:      issue = 1'b1;
            default:      issue = 1'b0;
        endcase
        icnt_n = icnt_base + cnt_bw'(issue);

        if (ns == W_WR)
            addr_n = w_sel + addr_bw'(kij_sel) * addr_bw'(col) + addr_bw'(icnt_base);
        else
            addr_n = a_sel + addr_bw'(icnt_base);
    end

    // State, counters, sampled layer parameters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= IDLE; icnt <= '0; kij <= '0;
            n_kij_r <= '0; n_nij_r <= '0; w_base_r <= '0; a_base_r <= '0;
            cen_q <= 1'b1; addr_q <= '0; l0_wr_q <= 1'b0; l0_rd_q <= 1'b0;
            exec_q <= 1'b0; kload_q <= 1'b0; ofifo_q <= 1'b0; mode_q <= 1'b0;
            busy_q <= 1'b0; done_q <= 1'b0;
        end else begin
            st   <= ns;
            icnt <= icnt_n;
            if (st == IDLE && bus.start) begin
                n_kij_r  <= bus.n_kij;
                n_nij_r  <= bus.n_nij;
                w_base_r <= bus.w_base;
                a_base_r <= bus.a_base;
                kij      <= '0;
            end else if (ns == NEXT && st != NEXT) begin
                kij <= kij + cnt_bw'(1);
            end
            cen_q   <= !(issue && (ns == W_WR || ns == A_WR));
            if (issue && (ns == W_WR || ns == A_WR)) addr_q <= addr_n;
            // SRAM read data lands in L0 one cycle after the read.
            l0_wr_q <= !cen_q;
            kload_q <= issue && ns == W_LOAD;
            exec_q  <= issue && ns == EXEC;
            l0_rd_q <= issue && (ns == W_LOAD || ns == EXEC);
            ofifo_q <= issue && ns == DRAIN;
            mode_q  <= (ns != IDLE) && os_sel;
            busy_q  <= (ns != IDLE);
            done_q  <= (ns == DONE);
        end
    end

    assign bus.inst      = {mode_q, ofifo_q, 26'b0, ofifo_q, 2'b0, l0_rd_q, l0_wr_q, exec_q, kload_q};
    assign bus.xmem_cen  = cen_q;
    assign bus.xmem_addr = addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: directed bench for corelet_ctrl (row=col=8).
// A negedge monitor tallies strobes and SRAM reads; tests compare the
// tallies against hand-computed values.
module tb_corelet_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    corelet_ctrl_if #(.addr_bw(11), .cnt_bw(8)) bus();
    corelet_ctrl #(.row(8), .col(8), .addr_bw(11), .cnt_bw(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    localparam logic [34:0] USED = 35'h6_0000_004F;

    int checks = 0, fails = 0, cyc = 0;
    int n_wr, n_kl, n_ex, n_l0rd, n_ofr, n_sfp, n_sfp_mis, n_done, n_other;
    int n_mode_err, n_rd_bad, n_full_rd, n_full_wr;
    int first_wr, first_kl, done_cyc, last_rd, t0;
    bit prev_full, prev_valid, exp_mode;
    logic [10:0] aq[$];
    logic [10:0] eq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Tally outputs mid-cycle; flags are remembered for the next cycle
    // because every strobe reacts to the previous cycle's status.
    always @(negedge clk) begin
        if (reset) begin
            prev_full = 1'b0; prev_valid = 1'b0;
        end else begin
            if (!bus.xmem_cen) begin
                aq.push_back(bus.xmem_addr);
                if (prev_full) n_full_rd++;
            end
            if (bus.inst[2]) begin
                n_wr++;
                if (first_wr < 0) first_wr = cyc;
                if (prev_full) n_full_wr++;
            end
            if (bus.inst[0]) begin n_kl++; if (first_kl < 0) first_kl = cyc; end
            if (bus.inst[1]) n_ex++;
            if (bus.inst[3]) n_l0rd++;
            if (bus.inst[6]) begin n_ofr++; last_rd = cyc; if (!prev_valid) n_rd_bad++; end
            if (bus.inst[33]) n_sfp++;
            if (bus.inst[33] !== bus.inst[6]) n_sfp_mis++;
            if (bus.done) begin n_done++; done_cyc = cyc; end
            if (bus.busy && bus.inst[34] !== exp_mode) n_mode_err++;
            if ((bus.inst & ~USED) != 35'd0) n_other++;
            prev_full  = bus.l0_full;
            prev_valid = bus.ofifo_valid;
        end
    end

    task automatic clr();
        n_wr = 0; n_kl = 0; n_ex = 0; n_l0rd = 0; n_ofr = 0; n_sfp = 0; n_sfp_mis = 0;
        n_done = 0; n_other = 0; n_mode_err = 0; n_rd_bad = 0; n_full_rd = 0; n_full_wr = 0;
        first_wr = -1; first_kl = -1; done_cyc = -1; last_rd = -1;
        aq.delete(); eq.delete();
    endtask

    task automatic pulse_start(input int nk, input int nn, input int wb, input int ab, input bit md);
        bus.n_kij = 8'(nk); bus.n_nij = 8'(nn); bus.w_base = 11'(wb); bus.a_base = 11'(ab);
        bus.mode = md;
        @(posedge clk); #1; bus.start = 1'b1; t0 = cyc;
        @(posedge clk); #1; bus.start = 1'b0;
    endtask

    // Run one layer. full_rel: l0_full high for 5 cycles from t0+full_rel;
    // rs_rel: stray start pulse at t0+rs_rel; tog: ofifo_valid toggles.
    task automatic run_layer(input string tag, input int nk, input int nn, input int wb,
                             input int ab, input bit md, input bit tog, input int full_rel,
                             input int rs_rel);
        bit got_done;
        clr();
        got_done = 1'b0;
        pulse_start(nk, nn, wb, ab, md);
        chk($sformatf("%s_busy_t1", tag), bus.busy, 1);
        chk($sformatf("%s_cen_t1", tag), bus.xmem_cen, 0);
        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(posedge clk); #1;
            if (tog) bus.ofifo_valid = ~bus.ofifo_valid;
            if (full_rel > 0 && cyc == t0 + full_rel) bus.l0_full = 1'b1;
            if (full_rel > 0 && cyc == t0 + full_rel + 5) bus.l0_full = 1'b0;
            if (rs_rel > 0 && cyc == t0 + rs_rel) begin bus.start = 1'b1; bus.n_kij = 8'd5; end
            else bus.start = 1'b0;
            if (bus.done) got_done = 1'b1;
        end
        chk($sformatf("%s_done_seen", tag), got_done, 1);
        bus.ofifo_valid = 1'b1;
        bus.l0_full = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s_busy_end", tag), bus.busy, 0);
        chk($sformatf("%s_done_cnt", tag), n_done, 1);
        chk($sformatf("%s_done_after_rd", tag), done_cyc - last_rd, 1);
        chk($sformatf("%s_sfp_pair", tag), n_sfp_mis, 0);
        chk($sformatf("%s_other_bits", tag), n_other, 0);
        chk($sformatf("%s_mode_bit", tag), n_mode_err, 0);
        chk($sformatf("%s_first_wr", tag), first_wr - t0, 2);
    endtask

    task automatic chk_addrs(input string tag);
        int n;
        chk($sformatf("%s_nrd", tag), aq.size(), eq.size());
        n = (aq.size() < eq.size()) ? aq.size() : eq.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_a%0d", tag, i), aq[i], eq[i]);
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.n_kij = 8'd1; bus.n_nij = 8'd1;
        bus.w_base = '0; bus.a_base = '0; bus.l0_full = 1'b0; bus.l0_ready = 1'b1;
        bus.ofifo_valid = 1'b1; exp_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst", bus.inst, 0);
        chk("rst_cen", bus.xmem_cen, 1);
        chk("rst_addr", bus.xmem_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // T1: one kij, four activations, no stalls.
        run_layer("t1", 1, 4, 0, 16, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) eq.push_back(11'(i));
        for (int i = 0; i < 4; i++) eq.push_back(11'(16 + i));
        chk_addrs("t1");
        chk("t1_kl", n_kl, 8);  chk("t1_ex", n_ex, 4);   chk("t1_l0rd", n_l0rd, 12);
        chk("t1_ofr", n_ofr, 4); chk("t1_sfp", n_sfp, 4); chk("t1_wr", n_wr, 12);
        chk("t1_first_kl", first_kl - t0, 10);
        chk("t1_done_cyc", done_cyc - t0, 47);

        // T2: three kij, two activations; a stray start mid-layer is ignored.
        run_layer("t2", 3, 2, 0, 16, 1'b0, 1'b0, 0, 20);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) eq.push_back(11'(8 * k + i));
            eq.push_back(11'd16); eq.push_back(11'd17);
        end
        chk_addrs("t2");
        chk("t2_sfp", n_sfp, 6); chk("t2_kl", n_kl, 24); chk("t2_wr", n_wr, 30);

        // T3: l0_full high for 5 cycles inside A_WR (A_WR spans t0+34..).
        run_layer("t3", 1, 8, 0, 16, 1'b0, 1'b0, 36, 0);
        for (int i = 0; i < 8; i++) eq.push_back(11'(i));
        for (int i = 0; i < 8; i++) eq.push_back(11'(16 + i));
        chk_addrs("t3");
        chk("t3_rd_full", n_full_rd, 0);
        chk("t3_wr_le1", n_full_wr <= 1, 1);
        chk("t3_wr", n_wr, 16);
        chk("t3_ex", n_ex, 8);

        // T4: ofifo_valid toggles every cycle.
        run_layer("t4", 1, 4, 0, 16, 1'b0, 1'b1, 0, 0);
        chk("t4_rd_bad", n_rd_bad, 0);
        chk("t4_ofr", n_ofr, 4);
        chk("t4_sfp", n_sfp, 4);

        // T5: reset during EXEC, then a clean layer.
        clr();
        pulse_start(1, 4, 0, 16, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(posedge clk); #1;
                if (bus.inst[1]) seen = 1'b1;
            end
            chk("t5_exec_seen", seen, 1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_inst", bus.inst, 0);
        chk("t5_cen", bus.xmem_cen, 1);
        chk("t5_busy", bus.busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_wr", n_wr, 0);
        chk("t5_no_rd", aq.size(), 0);
        run_layer("t5b", 1, 4, 0, 16, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) eq.push_back(11'(i));
        for (int i = 0; i < 4; i++) eq.push_back(11'(16 + i));
        chk_addrs("t5b");
        chk("t5b_kl", n_kl, 8); chk("t5b_ofr", n_ofr, 4);

        // T6: mode=1, two kij, three activations.
`ifdef CORELET_CTRL_OS_EN
        exp_mode = 1'b1;
        run_layer("t6", 2, 3, 0, 16, 1'b1, 1'b0, 0, 0);
        chk("t6_kl", n_kl, 0); chk("t6_ofr", n_ofr, 0); chk("t6_sfp", n_sfp, 0);
        chk("t6_ex", n_ex, 6); chk("t6_wr", n_wr, 6);
        for (int k = 0; k < 2; k++) for (int i = 0; i < 3; i++) eq.push_back(11'(16 + i));
        chk_addrs("t6");
`else
        exp_mode = 1'b0;
        run_layer("t6", 2, 3, 0, 16, 1'b1, 1'b0, 0, 0);
        chk("t6_kl", n_kl, 16); chk("t6_ofr", n_ofr, 6); chk("t6_ex", n_ex, 6);
        chk("t6_wr", n_wr, 22);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
